ghost_timer_unit: RTL and testbench
===================================

// Module: ghost_timer_unit
// PURPOSE
// - Parametrised successor to the ad-hoc 60 Hz divider and speaker logic in the ghostchip top level.
// - Generates the frame tick (CPU vsync) and holds NUM_TIMERS down-counting timers (CHIP-8 DT/ST and extras).
// - Drives a programmable-pitch complementary piezo pair while the sound timer is non-zero.
// - Sits between cpu (timer reads and writes) and the board speaker pins.
// PARAMETERS
// - CLK_HZ      12_000_000  system clock frequency
// - TICK_HZ     60          timer decrement rate; TICK_DIV = CLK_HZ/TICK_HZ, an integer >= 2
// - NUM_TIMERS  2           number of timer channels, >= 2
// - TIMER_W     8           timer width in bits
// - SOUND_CH    1           channel index that gates the speaker
// - TONE_W      16          width of tone_period
// PORTS
// - clk          in   1           system clock
// - rst          in   1           synchronous reset, active-high
// - wr_en        in   1           load timer[wr_sel] with wr_data
// - wr_sel       in   SEL_W       SEL_W = $clog2(NUM_TIMERS); values >= NUM_TIMERS are ignored
// - wr_data      in   TIMER_W     load value
// - rd_sel       in   SEL_W       read select
// - rd_data      out  TIMER_W     registered read data
// - tick         out  1           one-cycle pulse at TICK_HZ
// - zero         out  NUM_TIMERS  bit i = (timer[i] == 0)
// - tone_period  in   TONE_W      tone half-period in clk cycles; 0 = silent
// - mute         in   1           active-high; forces the speaker off
// - speaker      out  1           piezo drive
// - speaker_inv  out  1           complementary piezo drive
// BEHAVIOUR
// - Reset values: prescaler=0, all timers=0, tick=0, rd_data=0, zero=all 1s, speaker=speaker_inv=0, tone state=0.
// - Prescaler counts 0..TICK_DIV-1 and wraps. tick is registered and high for exactly the cycle after the count equals TICK_DIV-1.
//   - The first tick occurs TICK_DIV cycles after rst deasserts. Ticks are then exactly TICK_DIV cycles apart.
// - Timers: when tick=1, every non-zero timer decrements by 1. A timer at 0 saturates at 0 and never wraps.
// - Write: wr_en loads the selected timer at the next edge.
//   - A write and a tick in the same cycle on the same channel: the write wins, and the loaded value is not decremented that tick.
//   - Other channels still decrement.
// - rd_data <= timer[rd_sel] as held before the edge, giving 1-cycle latency. An out-of-range rd_sel returns 0.
// - zero is combinational from the timer registers.
// - Tone: active = (timer[SOUND_CH] != 0) && (tone_period != 0) && !mute.
//   - While active, the tone counter increments each cycle.
//   - When the counter >= tone_period-1, the counter clears and tone_q toggles. Using >= means a period decrease mid-run toggles on the next cycle.
//   - While inactive, the counter and tone_q are held at 0.
// - speaker <= active & tone_q; speaker_inv <= active & ~tone_q (both registered).
//   - Both outputs are 0 when inactive, so there is no DC across the piezo.
//   - The outputs go low one cycle after active drops.
// - rst mid-operation: all state returns to reset values at that edge, and the tick phase restarts.
// STRUCTURE
// - Package ghost_pkg holds TIMER_W, NUM_TIMERS, the channel constants CH_DT=0 and CH_ST=1, and CLK_HZ.
// - Sub-module ghost_tone_gen contains the tone counter, tone_q and the complementary output registers, with inputs clk, rst, active and tone_period.
// - The prescaler and the timer array stay inline in ghost_timer_unit.
// TESTING
// - Parameters CLK_HZ=600, TICK_HZ=60 (TICK_DIV=10).
// 1. Release rst -> tick at cycles 10, 20, 30; each pulse is exactly 1 cycle wide.
// 2. Write timer0=3 -> reads 3, 2, 1, 0 across successive ticks, then stays 0. zero[0] rises after the third tick.
// 3. Write timer1=5 in a tick cycle while timer0=4 -> timer1=5, timer0=3; after the next tick timer1=4.
// 4. timer1=2, tone_period=4 -> speaker toggles every 4 cycles and speaker_inv is its exact complement.
//    Both go 0 one cycle after timer1 reaches 0. mute=1 forces both to 0.
// 5. tone_period=0 -> silent. Change tone_period 8->2 while the counter is 5 -> toggle on the next cycle.
// 6. Assert rst mid-count with timers non-zero -> all cleared and zero=all 1s. The next tick arrives 10 cycles after release.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared constants for the ghostchip timer block: default sizing and CHIP-8 channel indices.
package ghost_pkg;

    localparam int unsigned CLK_HZ     = 12_000_000;
    localparam int unsigned TIMER_W    = 8;
    localparam int unsigned NUM_TIMERS = 2;

    localparam int unsigned CH_DT = 0;
    localparam int unsigned CH_ST = 1;

endpackage

// File: rtl/ghost_tone_gen.sv
// Programmable-pitch square wave for the piezo pair; silent and reset-to-zero whenever inactive.
module ghost_tone_gen #(
    parameter int unsigned TONE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic [TONE_W-1:0] tone_period,
    output logic              speaker,
    output logic              speaker_inv
);

    logic [TONE_W-1:0] cnt_q;
    logic              tone_q;
    logic              spk_q;
    logic              spk_inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            tone_q    <= 1'b0;
            spk_q     <= 1'b0;
            spk_inv_q <= 1'b0;
        end else begin
            // Outputs use tone_q before this edge so both legs fall together when active drops.
            spk_q     <= active & tone_q;
            spk_inv_q <= active & ~tone_q;
            if (!active) begin
                cnt_q  <= '0;
                tone_q <= 1'b0;
            end else if (cnt_q >= tone_period - TONE_W'(1)) begin
                cnt_q  <= '0;
                tone_q <= ~tone_q;
            end else begin
                cnt_q <= cnt_q + TONE_W'(1);
            end
        end
    end

    assign speaker     = spk_q;
    assign speaker_inv = spk_inv_q;

endmodule

// File: rtl/ghost_timer_unit.sv
// Frame tick prescaler, CHIP-8 style down-counting timer array and sound-timer-gated piezo driver.
module ghost_timer_unit
    import ghost_pkg::*;
#(
    parameter int unsigned CLK_HZ     = ghost_pkg::CLK_HZ,
    parameter int unsigned TICK_HZ    = 60,
    parameter int unsigned NUM_TIMERS = ghost_pkg::NUM_TIMERS,
    parameter int unsigned TIMER_W    = ghost_pkg::TIMER_W,
    parameter int unsigned SOUND_CH   = CH_ST,
    parameter int unsigned TONE_W     = 16,
    parameter int unsigned SEL_W      = $clog2(NUM_TIMERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [TIMER_W-1:0]    wr_data,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [TIMER_W-1:0]    rd_data,
    output logic                  tick,
    output logic [NUM_TIMERS-1:0] zero,
    input  logic [TONE_W-1:0]     tone_period,
    input  logic                  mute,
    output logic                  speaker,
    output logic                  speaker_inv
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W    = $clog2(TICK_DIV);

    logic [PRE_W-1:0]   pre_q;
    logic               tick_q;
    logic [TIMER_W-1:0] timer_q [NUM_TIMERS];
    logic [TIMER_W-1:0] rd_data_q;
    logic [TIMER_W-1:0] rd_data_d;
    logic               active;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (pre_q == PRE_W'(TICK_DIV - 1));
            if (pre_q == PRE_W'(TICK_DIV - 1)) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

    // A write to a channel overrides that channel's decrement in the same cycle.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            if (rst) begin
                timer_q[i] <= '0;
            end else if (wr_en && (SEL_W'(i) == wr_sel)) begin
                timer_q[i] <= wr_data;
            end else if (tick_q && (timer_q[i] != '0)) begin
                timer_q[i] <= timer_q[i] - TIMER_W'(1);
            end
        end
    end

    // Out-of-range selects match no channel and read as 0.
    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            if (SEL_W'(i) == rd_sel) begin
                rd_data_d = timer_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        zero = '0;
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            zero[i] = (timer_q[i] == '0);
        end
    end

    assign active  = (timer_q[SOUND_CH] != '0) && (tone_period != '0) && !mute;
    assign tick    = tick_q;
    assign rd_data = rd_data_q;

    ghost_tone_gen #(
        .TONE_W (TONE_W)
    ) u_tone (
        .clk         (clk),
        .rst         (rst),
        .active      (active),
        .tone_period (tone_period),
        .speaker     (speaker),
        .speaker_inv (speaker_inv)
    );

endmodule

// File: tb/tb_ghost_timer_unit.sv
// Directed and randomised checks of ghost_timer_unit against a cycle-level behavioural model.
module tb_ghost_timer_unit;

    localparam int NT = 3;
    localparam int SW = 2;
    localparam int TW = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_sel = '0;
    logic [TW-1:0] wr_data = '0;
    logic [SW-1:0] rd_sel = '0;
    logic [TW-1:0] rd_data;
    logic          tick;
    logic [NT-1:0] zero;
    logic [PW-1:0] tone_period = '0;
    logic          mute = 1'b0;
    logic          speaker;
    logic          speaker_inv;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state: edges since reset release, timer values, tone phase.
    int m_since;
    bit m_tick;
    int m_t [NT];
    int m_rd;
    int m_el;
    bit m_tone;
    bit m_spk;
    bit m_inv;

    ghost_timer_unit #(
        .CLK_HZ     (600),
        .TICK_HZ    (60),
        .NUM_TIMERS (NT),
        .TIMER_W    (TW),
        .SOUND_CH   (1),
        .TONE_W     (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .tick        (tick),
        .zero        (zero),
        .tone_period (tone_period),
        .mute        (mute),
        .speaker     (speaker),
        .speaker_inv (speaker_inv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  t_old [NT];
        bit  act;
        if (rst) begin
            m_since = 0; m_tick = 0; m_rd = 0; m_el = 0;
            m_tone = 0; m_spk = 0; m_inv = 0;
            for (int i = 0; i < NT; i++) m_t[i] = 0;
        end else begin
            t_old = m_t;
            act = (t_old[1] != 0) && (tone_period != 0) && !mute;
            for (int i = 0; i < NT; i++) begin
                if (wr_en && int'(wr_sel) == i) m_t[i] = int'(wr_data);
                else if (m_tick && m_t[i] > 0) m_t[i] = m_t[i] - 1;
            end
            m_rd  = (int'(rd_sel) < NT) ? t_old[int'(rd_sel)] : 0;
            m_spk = act && m_tone;
            m_inv = act && !m_tone;
            if (!act) begin
                m_el = 0; m_tone = 0;
            end else if (m_el >= int'(tone_period) - 1) begin
                m_el = 0; m_tone = !m_tone;
            end else begin
                m_el++;
            end
            m_since++;
            m_tick = (m_since % 10 == 0);
        end
    endtask

    task automatic check_all();
        logic [NT-1:0] z;
        for (int i = 0; i < NT; i++) z[i] = (m_t[i] == 0);
        chk("tick", 32'(tick), 32'(m_tick));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
        chk("zero", 32'(zero), 32'(z));
        chk("speaker", 32'(speaker), 32'(m_spk));
        chk("speaker_inv", 32'(speaker_inv), 32'(m_inv));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic write(input int sel, input int data);
        wr_en = 1'b1; wr_sel = SW'(sel); wr_data = TW'(data);
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_zero", 32'(zero), 32'h7);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_rd", 32'(rd_data), 32'h0);
        chk("rst_spk", 32'({speaker, speaker_inv}), 32'h0);

        // 1: tick at cycles 10, 20, 30, one cycle wide
        rst = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            chk("tick_phase", 32'(tick), 32'((c % 10) == 0));
        end

        // 2: timer0 counts 3,2,1,0 and saturates
        write(0, 3);
        rd_sel = '0;
        for (int c = 0; c < 45; c++) step();
        chk("t0_saturated", 32'(rd_data), 32'h0);
        chk("t0_zero", 32'(zero[0]), 32'h1);

        // 3: write timer1 during a tick cycle while timer0 is 4
        write(0, 4);
        for (int c = 0; c < 12 && !m_tick; c++) step();
        chk("tick_found", 32'(tick), 32'h1);
        write(1, 5);
        rd_sel = 2'd1;
        step();
        chk("t1_write_wins", 32'(rd_data), 32'h5);
        rd_sel = 2'd0;
        step();
        chk("t0_decremented", 32'(rd_data), 32'h3);

        // 4: tone with timer1 = 2, period 4, then run out, then mute
        tone_period = 16'd4;
        write(1, 2);
        for (int c = 0; c < 30; c++) step();
        chk("tone_off_after_st", 32'({speaker, speaker_inv}), 32'h0);
        write(1, 9);
        for (int c = 0; c < 6; c++) step();
        mute = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("mute_silent", 32'({speaker, speaker_inv}), 32'h0);
        mute = 1'b0;

        // 5: period 0 is silent; shrinking period mid-run toggles immediately
        tone_period = '0;
        for (int c = 0; c < 5; c++) step();
        tone_period = 16'd8;
        for (int c = 0; c < 20 && m_el != 5; c++) step();
        chk("tone_count5", 32'(m_el), 32'd5);
        tone_period = 16'd2;
        for (int c = 0; c < 6; c++) step();

        // 6: reset mid-count
        write(0, 7);
        write(1, 7);
        rst = 1'b1;
        step();
        chk("midrst_zero", 32'(zero), 32'h7);
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk("midrst_tick", 32'(tick), 32'(c == 10));
        end

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            wr_en       = ($urandom_range(0, 5) == 0);
            wr_sel      = SW'($urandom_range(0, 3));
            wr_data     = TW'($urandom_range(0, 6));
            rd_sel      = SW'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) tone_period = PW'($urandom_range(0, 6));
            mute        = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; wr_en = 1'b0; mute = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
